// File: rtl/moesi_pkg.sv
// Shared encodings and response record types for the MOESI state array.
package moesi_pkg;

    localparam logic [2:0] ST_M = 3'b000;
    localparam logic [2:0] ST_O = 3'b001;
    localparam logic [2:0] ST_E = 3'b010;
    localparam logic [2:0] ST_S = 3'b011;
    localparam logic [2:0] ST_I = 3'b100;

    localparam logic [3:0] SNP_RD    = 4'b0001;
    localparam logic [3:0] SNP_RDINV = 4'b0111;
    localparam logic [3:0] SNP_INV   = 4'b1101;

    localparam logic [1:0] OP_RD_HIT = 2'b00;
    localparam logic [1:0] OP_WR_HIT = 2'b01;
    localparam logic [1:0] OP_FILL   = 2'b10;
    localparam logic [1:0] OP_EVICT  = 2'b11;

    typedef struct packed {
        logic       valid;
        logic [2:0] prev;
        logic [2:0] next;
        logic       need_inv;
        logic       wb;
        logic       err;
    } cpu_rsp_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] state;
        logic       supply;
        logic       dirty;
    } snp_rsp_t;

    localparam cpu_rsp_t CPU_RSP_IDLE = '{valid: 1'b0, prev: ST_I, next: ST_I,
                                          need_inv: 1'b0, wb: 1'b0, err: 1'b0};
    localparam snp_rsp_t SNP_RSP_IDLE = '{valid: 1'b0, state: ST_I,
                                          supply: 1'b0, dirty: 1'b0};

    // Only M and O own data that memory does not have; S is always clean.
    function automatic logic is_dirty(input logic [2:0] st);
        return (st == ST_M) || (st == ST_O);
    endfunction

    function automatic logic can_supply(input logic [2:0] st);
        return (st == ST_M) || (st == ST_O) || (st == ST_E);
    endfunction

endpackage

// File: rtl/moesi_transition.sv
// Pure combinational next-state and flag logic for one CPU and one snoop transition.
module moesi_transition
    import moesi_pkg::*;
(
    input  logic [1:0] cpu_op,
    input  logic [2:0] cpu_prev,
    input  logic       cpu_from_bus,
    input  logic       cpu_shared,
    output logic [2:0] cpu_next,
    output logic       cpu_wr,
    output logic       cpu_need_inv,
    output logic       cpu_wb,
    output logic       cpu_err,
    input  logic [3:0] snp_type,
    input  logic       snp_hit,
    input  logic [2:0] snp_prev,
    output logic [2:0] snp_next,
    output logic       snp_wr,
    output logic       snp_supply,
    output logic       snp_dirty
);

    always_comb begin
        cpu_next     = cpu_prev;
        cpu_wr       = 1'b0;
        cpu_need_inv = 1'b0;
        cpu_wb       = 1'b0;
        cpu_err      = 1'b0;
        case (cpu_op)
            OP_RD_HIT: cpu_err = (cpu_prev == ST_I);
            OP_WR_HIT: begin
                // A hit on an invalid line is a controller bug: flag it and leave the array alone.
                if (cpu_prev == ST_I) begin
                    cpu_err = 1'b1;
                end else begin
                    cpu_next     = ST_M;
                    cpu_wr       = 1'b1;
                    cpu_need_inv = (cpu_prev == ST_S) || (cpu_prev == ST_O);
                end
            end
            OP_FILL: begin
                cpu_next = (cpu_from_bus || cpu_shared) ? ST_S : ST_E;
                cpu_wr   = 1'b1;
            end
            default: begin
                cpu_next = ST_I;
                cpu_wr   = 1'b1;
                cpu_wb   = is_dirty(cpu_prev);
            end
        endcase
    end

    always_comb begin
        snp_next   = snp_prev;
        snp_wr     = 1'b0;
        snp_supply = 1'b0;
        snp_dirty  = is_dirty(snp_prev);
        case (snp_type)
            SNP_RD: begin
                snp_supply = can_supply(snp_prev);
                snp_wr     = snp_hit;
                if (snp_prev == ST_E) begin
                    snp_next = ST_S;
                end else if (snp_prev == ST_M) begin
                    snp_next = ST_O;
                end
            end
            SNP_RDINV: begin
                snp_supply = can_supply(snp_prev);
                snp_wr     = snp_hit;
                snp_next   = ST_I;
            end
            SNP_INV: begin
                snp_wr   = snp_hit;
                snp_next = ST_I;
            end
            default: snp_next = snp_prev;
        endcase
    end

endmodule

// File: rtl/moesi_state_array.sv
// Per-set/per-way MOESI state store with one CPU and one snoop update per cycle.
module moesi_state_array
    import moesi_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2,
    parameter int IDX_W    = $clog2(NUM_SETS),
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             cpu_valid,
    output logic             cpu_ready,
    input  logic [1:0]       cpu_op,
    input  logic [IDX_W-1:0] cpu_index,
    input  logic [WAY_W-1:0] cpu_way,
    input  logic             cpu_from_bus,
    input  logic             cpu_shared,
    output logic [2:0]       cpu_cur_state,
    output logic             cpu_resp_valid,
    output logic [2:0]       cpu_prev_state,
    output logic [2:0]       cpu_next_state,
    output logic             cpu_need_inv,
    output logic             cpu_wb,
    output logic             cpu_err,
    input  logic             snp_valid,
    input  logic [3:0]       snp_type,
    input  logic [IDX_W-1:0] snp_index,
    input  logic             snp_hit,
    input  logic [WAY_W-1:0] snp_way,
    output logic             snp_resp_valid,
    output logic [2:0]       snp_resp_state,
    output logic             snp_resp_supply,
    output logic             snp_resp_dirty
);

    localparam int ENTRIES = NUM_SETS * NUM_WAYS;

    logic [2:0] state_q [ENTRIES];
    logic [2:0] state_d [ENTRIES];

    logic [IDX_W+WAY_W-1:0] cpu_addr;
    logic [IDX_W+WAY_W-1:0] snp_addr;
    logic [2:0] cpu_prev;
    logic [2:0] snp_prev;
    logic       collision;
    logic       cpu_accept;
    logic       snp_apply;

    logic [2:0] t_cpu_next;
    logic       t_cpu_wr;
    logic       t_cpu_need_inv;
    logic       t_cpu_wb;
    logic       t_cpu_err;
    logic [2:0] t_snp_next;
    logic       t_snp_wr;
    logic       t_snp_supply;
    logic       t_snp_dirty;

    cpu_rsp_t cpu_rsp_q, cpu_rsp_d;
    snp_rsp_t snp_rsp_q, snp_rsp_d;

    assign cpu_addr = {cpu_index, cpu_way};
    assign snp_addr = {snp_index, snp_way};
    assign cpu_prev = state_q[cpu_addr];
    assign snp_prev = snp_hit ? state_q[snp_addr] : ST_I;

    // cpu_valid/cpu_ready: a request transfers on a rising edge where both are high.
    // Ready depends only on the snoop port, so a stalled requester holds valid and payload
    // and is re-evaluated against the post-snoop line state on the following cycle.
    assign collision  = snp_valid && snp_hit && (snp_addr == cpu_addr);
    assign cpu_ready  = !collision;
    assign cpu_accept = cpu_valid && cpu_ready;
    assign snp_apply  = snp_valid && t_snp_wr;

    assign cpu_cur_state = cpu_prev;

    moesi_transition u_transition (
        .cpu_op       (cpu_op),
        .cpu_prev     (cpu_prev),
        .cpu_from_bus (cpu_from_bus),
        .cpu_shared   (cpu_shared),
        .cpu_next     (t_cpu_next),
        .cpu_wr       (t_cpu_wr),
        .cpu_need_inv (t_cpu_need_inv),
        .cpu_wb       (t_cpu_wb),
        .cpu_err      (t_cpu_err),
        .snp_type     (snp_type),
        .snp_hit      (snp_hit),
        .snp_prev     (snp_prev),
        .snp_next     (t_snp_next),
        .snp_wr       (t_snp_wr),
        .snp_supply   (t_snp_supply),
        .snp_dirty    (t_snp_dirty)
    );

    // Both writes can land in one cycle; they never target the same entry because a collision blocks the CPU.
    always_comb begin
        state_d = state_q;
        if (snp_apply) begin
            state_d[snp_addr] = t_snp_next;
        end
        if (cpu_accept && t_cpu_wr) begin
            state_d[cpu_addr] = t_cpu_next;
        end
    end

    always_comb begin
        cpu_rsp_d = CPU_RSP_IDLE;
        if (cpu_accept) begin
            cpu_rsp_d.valid    = 1'b1;
            cpu_rsp_d.prev     = cpu_prev;
            cpu_rsp_d.next     = t_cpu_next;
            cpu_rsp_d.need_inv = t_cpu_need_inv;
            cpu_rsp_d.wb       = t_cpu_wb;
            cpu_rsp_d.err      = t_cpu_err;
        end
    end

    always_comb begin
        snp_rsp_d = SNP_RSP_IDLE;
        if (snp_valid) begin
            snp_rsp_d.valid  = 1'b1;
            snp_rsp_d.state  = snp_prev;
            snp_rsp_d.supply = t_snp_supply;
            snp_rsp_d.dirty  = t_snp_dirty;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= '{default: ST_I};
            cpu_rsp_q <= CPU_RSP_IDLE;
            snp_rsp_q <= SNP_RSP_IDLE;
        end else begin
            state_q   <= state_d;
            cpu_rsp_q <= cpu_rsp_d;
            snp_rsp_q <= snp_rsp_d;
        end
    end

    assign cpu_resp_valid  = cpu_rsp_q.valid;
    assign cpu_prev_state  = cpu_rsp_q.prev;
    assign cpu_next_state  = cpu_rsp_q.next;
    assign cpu_need_inv    = cpu_rsp_q.need_inv;
    assign cpu_wb          = cpu_rsp_q.wb;
    assign cpu_err         = cpu_rsp_q.err;
    assign snp_resp_valid  = snp_rsp_q.valid;
    assign snp_resp_state  = snp_rsp_q.state;
    assign snp_resp_supply = snp_rsp_q.supply;
    assign snp_resp_dirty  = snp_rsp_q.dirty;

endmodule

// File: tb/tb_moesi_state_array.sv
// Self-checking bench for moesi_state_array: directed scenarios plus randomized traffic against a line-state model.
module tb_moesi_state_array;

    localparam logic [2:0] M = 3'b000;
    localparam logic [2:0] O = 3'b001;
    localparam logic [2:0] E = 3'b010;
    localparam logic [2:0] S = 3'b011;
    localparam logic [2:0] I = 3'b100;
    localparam logic [3:0] RD    = 4'b0001;
    localparam logic [3:0] RDINV = 4'b0111;
    localparam logic [3:0] INV   = 4'b1101;
    localparam logic [1:0] RDH = 2'b00;
    localparam logic [1:0] WRH = 2'b01;
    localparam logic [1:0] FIL = 2'b10;
    localparam logic [1:0] EVI = 2'b11;

    logic       ACLK = 1'b0;
    logic       ARESETn = 1'b0;
    logic       cpu_valid = 1'b0;
    logic       cpu_ready;
    logic [1:0] cpu_op = 2'b00;
    logic [3:0] cpu_index = 4'd0;
    logic       cpu_way = 1'b0;
    logic       cpu_from_bus = 1'b0;
    logic       cpu_shared = 1'b0;
    logic [2:0] cpu_cur_state;
    logic       cpu_resp_valid;
    logic [2:0] cpu_prev_state;
    logic [2:0] cpu_next_state;
    logic       cpu_need_inv;
    logic       cpu_wb;
    logic       cpu_err;
    logic       snp_valid = 1'b0;
    logic [3:0] snp_type = 4'd0;
    logic [3:0] snp_index = 4'd0;
    logic       snp_hit = 1'b0;
    logic       snp_way = 1'b0;
    logic       snp_resp_valid;
    logic [2:0] snp_resp_state;
    logic       snp_resp_supply;
    logic       snp_resp_dirty;

    int total = 0;
    int bad = 0;

    // Reference model: coherence state of every line plus expected responses of the last edge.
    logic [2:0] mdl [16][2];
    logic       exp_cpu_rv, exp_inv, exp_wb, exp_err, exp_snp_rv, exp_supply, exp_dirty, exp_ready;
    logic [2:0] exp_prev, exp_next, exp_snp_state;
    logic [2:0] exp_q[$];

    moesi_state_array #(.NUM_SETS(16), .NUM_WAYS(2)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_op(cpu_op),
        .cpu_index(cpu_index), .cpu_way(cpu_way), .cpu_from_bus(cpu_from_bus),
        .cpu_shared(cpu_shared), .cpu_cur_state(cpu_cur_state),
        .cpu_resp_valid(cpu_resp_valid), .cpu_prev_state(cpu_prev_state),
        .cpu_next_state(cpu_next_state), .cpu_need_inv(cpu_need_inv),
        .cpu_wb(cpu_wb), .cpu_err(cpu_err),
        .snp_valid(snp_valid), .snp_type(snp_type), .snp_index(snp_index),
        .snp_hit(snp_hit), .snp_way(snp_way), .snp_resp_valid(snp_resp_valid),
        .snp_resp_state(snp_resp_state), .snp_resp_supply(snp_resp_supply),
        .snp_resp_dirty(snp_resp_dirty)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- driver tasks ----------------
    task automatic set_cpu(input logic v, input logic [1:0] op, input int idx, input int way,
                           input logic fb, input logic sh);
        cpu_valid = v; cpu_op = op; cpu_index = 4'(idx); cpu_way = 1'(way);
        cpu_from_bus = fb; cpu_shared = sh;
    endtask

    task automatic set_snp(input logic v, input logic [3:0] typ, input int idx, input logic hit,
                           input int way);
        snp_valid = v; snp_type = typ; snp_index = 4'(idx); snp_hit = hit; snp_way = 1'(way);
    endtask

    task automatic idle();
        cpu_valid = 1'b0;
        snp_valid = 1'b0;
    endtask

    // Computes the model's view of the coming edge, clocks, then commits the model.
    task automatic clk_step();
        logic       coll;
        logic [2:0] cp, sp, snew;
        int         ci, cw, si, sw;
        ci = int'(cpu_index); cw = int'(cpu_way); si = int'(snp_index); sw = int'(snp_way);
        exp_cpu_rv = 0; exp_inv = 0; exp_wb = 0; exp_err = 0;
        exp_snp_rv = 0; exp_supply = 0; exp_dirty = 0;
        exp_prev = I; exp_next = I; exp_snp_state = I;
        if (!ARESETn) begin
            @(posedge ACLK); #1;
            for (int s = 0; s < 16; s++) for (int w = 0; w < 2; w++) mdl[s][w] = I;
            return;
        end
        coll = snp_valid && snp_hit && (si == ci) && (sw == cw);
        cp = mdl[ci][cw];
        sp = snp_hit ? mdl[si][sw] : I;
        snew = sp;
        if (snp_valid) begin
            exp_snp_rv = 1;
            exp_snp_state = sp;
            exp_dirty = (sp == M || sp == O);
            exp_supply = (sp == M || sp == O || sp == E) && (snp_type == RD || snp_type == RDINV);
            exp_q.push_back(sp);
            if (snp_type == RD) snew = (sp == E) ? S : (sp == M) ? O : sp;
            else if (snp_type == RDINV || snp_type == INV) snew = I;
        end
        if (cpu_valid && !coll) begin
            exp_cpu_rv = 1;
            exp_prev = cp;
            case (cpu_op)
                RDH: begin exp_next = cp; exp_err = (cp == I); end
                WRH: begin
                    exp_err = (cp == I);
                    exp_next = (cp == I) ? I : M;
                    exp_inv = (cp == S || cp == O);
                end
                FIL: exp_next = (cpu_from_bus || cpu_shared) ? S : E;
                default: begin exp_next = I; exp_wb = (cp == M || cp == O); end
            endcase
        end
        @(posedge ACLK); #1;
        if (snp_valid && snp_hit) mdl[si][sw] = snew;
        if (exp_cpu_rv) mdl[ci][cw] = exp_next;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        ARESETn = 0; idle();
        clk_step(); clk_step();
        ARESETn = 1;
        clk_step();
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL reset_cpu_rv got=%b want=0", cpu_resp_valid); end
        total++; if (snp_resp_valid !== 1'b0) begin bad++; $display("FAIL reset_snp_rv got=%b want=0", snp_resp_valid); end
        total++; if ({cpu_need_inv, cpu_wb, cpu_err, snp_resp_supply, snp_resp_dirty} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {cpu_need_inv, cpu_wb, cpu_err, snp_resp_supply, snp_resp_dirty});
        end
        total++; if (cpu_prev_state !== I || cpu_next_state !== I || snp_resp_state !== I) begin
            bad++; $display("FAIL reset_states got=%b/%b/%b want=100", cpu_prev_state, cpu_next_state, snp_resp_state);
        end
        for (int s = 0; s < 16; s += 5) begin
            set_cpu(0, RDH, s, s % 2, 0, 0); #1;
            total++; if (cpu_cur_state !== I) begin bad++; $display("FAIL reset_line[%0d] got=%b want=%b", s, cpu_cur_state, I); end
        end
    endtask

    task automatic test_fill();
        set_cpu(1, FIL, 3, 1, 0, 0); #1;
        total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL fill_ready got=%b want=1", cpu_ready); end
        clk_step();
        total++; if (cpu_resp_valid !== 1'b1 || cpu_prev_state !== I || cpu_next_state !== E) begin
            bad++; $display("FAIL fill_excl got rv=%b prev=%b next=%b want rv=1 prev=100 next=010", cpu_resp_valid, cpu_prev_state, cpu_next_state);
        end
        cpu_valid = 0; #1;
        total++; if (cpu_cur_state !== E) begin bad++; $display("FAIL fill_cur got=%b want=%b", cpu_cur_state, E); end
        clk_step();
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL fill_pulse got=%b want=0", cpu_resp_valid); end
        set_cpu(1, FIL, 4, 0, 1, 0); clk_step();
        total++; if (cpu_next_state !== S) begin bad++; $display("FAIL fill_from_bus got=%b want=%b", cpu_next_state, S); end
        set_cpu(1, FIL, 4, 1, 0, 1); clk_step();
        total++; if (cpu_next_state !== S) begin bad++; $display("FAIL fill_shared got=%b want=%b", cpu_next_state, S); end
        idle();
    endtask

    task automatic test_write_hit();
        set_cpu(1, FIL, 5, 0, 0, 1); clk_step();
        set_cpu(1, WRH, 5, 0, 0, 0); clk_step();
        total++; if (cpu_prev_state !== S || cpu_next_state !== M || cpu_need_inv !== 1'b1 || cpu_err !== 1'b0) begin
            bad++; $display("FAIL wr_from_s got prev=%b next=%b inv=%b err=%b want 011/000/1/0", cpu_prev_state, cpu_next_state, cpu_need_inv, cpu_err);
        end
        set_cpu(1, FIL, 5, 1, 0, 0); clk_step();
        set_cpu(1, WRH, 5, 1, 0, 0); clk_step();
        total++; if (cpu_prev_state !== E || cpu_next_state !== M || cpu_need_inv !== 1'b0) begin
            bad++; $display("FAIL wr_from_e got prev=%b next=%b inv=%b want 010/000/0", cpu_prev_state, cpu_next_state, cpu_need_inv);
        end
        idle();
    endtask

    task automatic test_snoop_evict();
        set_snp(1, RD, 5, 1, 0); clk_step();
        total++; if (snp_resp_valid !== 1'b1 || snp_resp_state !== M || snp_resp_supply !== 1'b1 || snp_resp_dirty !== 1'b1) begin
            bad++; $display("FAIL snp_rd_m got rv=%b st=%b sup=%b dirty=%b want 1/000/1/1", snp_resp_valid, snp_resp_state, snp_resp_supply, snp_resp_dirty);
        end
        idle(); set_cpu(0, RDH, 5, 0, 0, 0); #1;
        total++; if (cpu_cur_state !== O) begin bad++; $display("FAIL snp_rd_to_o got=%b want=%b", cpu_cur_state, O); end
        set_cpu(1, EVI, 5, 0, 0, 0); clk_step();
        total++; if (cpu_prev_state !== O || cpu_next_state !== I || cpu_wb !== 1'b1) begin
            bad++; $display("FAIL evict_o got prev=%b next=%b wb=%b want 001/100/1", cpu_prev_state, cpu_next_state, cpu_wb);
        end
        set_cpu(1, RDH, 5, 0, 0, 0); clk_step();
        total++; if (cpu_err !== 1'b1 || cpu_prev_state !== I || cpu_next_state !== I) begin
            bad++; $display("FAIL rd_on_i got err=%b prev=%b next=%b want 1/100/100", cpu_err, cpu_prev_state, cpu_next_state);
        end
        set_cpu(1, EVI, 3, 1, 0, 0); clk_step();
        total++; if (cpu_prev_state !== E || cpu_wb !== 1'b0) begin
            bad++; $display("FAIL evict_e got prev=%b wb=%b want 010/0", cpu_prev_state, cpu_wb);
        end
        idle();
    endtask

    task automatic test_collision();
        set_cpu(1, FIL, 2, 1, 0, 1); clk_step();
        set_cpu(1, WRH, 2, 1, 0, 0); set_snp(1, INV, 2, 1, 1); #1;
        total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL coll_ready got=%b want=0", cpu_ready); end
        clk_step();
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL coll_no_cpu_rsp got=%b want=0", cpu_resp_valid); end
        total++; if (snp_resp_valid !== 1'b1 || snp_resp_state !== S || snp_resp_supply !== 1'b0 || snp_resp_dirty !== 1'b0) begin
            bad++; $display("FAIL coll_snp got rv=%b st=%b sup=%b dirty=%b want 1/011/0/0", snp_resp_valid, snp_resp_state, snp_resp_supply, snp_resp_dirty);
        end
        snp_valid = 0; #1;
        total++; if (cpu_ready !== 1'b1 || cpu_cur_state !== I) begin
            bad++; $display("FAIL coll_after got ready=%b cur=%b want 1/100", cpu_ready, cpu_cur_state);
        end
        clk_step();
        total++; if (cpu_resp_valid !== 1'b1 || cpu_err !== 1'b1 || cpu_next_state !== I) begin
            bad++; $display("FAIL coll_held got rv=%b err=%b next=%b want 1/1/100", cpu_resp_valid, cpu_err, cpu_next_state);
        end
        idle();
    endtask

    task automatic test_diff_ways();
        set_cpu(1, FIL, 7, 0, 0, 0); clk_step();
        set_cpu(1, FIL, 7, 1, 0, 1); clk_step();
        set_cpu(1, WRH, 7, 1, 0, 0); set_snp(1, RD, 7, 1, 0); #1;
        total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL diff_ready got=%b want=1", cpu_ready); end
        clk_step();
        total++; if (cpu_resp_valid !== 1'b1 || cpu_next_state !== M || cpu_need_inv !== 1'b1) begin
            bad++; $display("FAIL diff_cpu got rv=%b next=%b inv=%b want 1/000/1", cpu_resp_valid, cpu_next_state, cpu_need_inv);
        end
        total++; if (snp_resp_valid !== 1'b1 || snp_resp_state !== E || snp_resp_supply !== 1'b1 || snp_resp_dirty !== 1'b0) begin
            bad++; $display("FAIL diff_snp got rv=%b st=%b sup=%b dirty=%b want 1/010/1/0", snp_resp_valid, snp_resp_state, snp_resp_supply, snp_resp_dirty);
        end
        idle(); set_cpu(0, RDH, 7, 0, 0, 0); #1;
        total++; if (cpu_cur_state !== S) begin bad++; $display("FAIL diff_e_to_s got=%b want=%b", cpu_cur_state, S); end
    endtask

    task automatic test_back_to_back();
        set_snp(1, RD, 7, 0, 1); clk_step();
        total++; if (snp_resp_valid !== 1'b1 || snp_resp_state !== I || snp_resp_supply !== 1'b0) begin
            bad++; $display("FAIL b2b_miss got rv=%b st=%b sup=%b want 1/100/0", snp_resp_valid, snp_resp_state, snp_resp_supply);
        end
        set_snp(1, 4'b0010, 7, 1, 0); clk_step();
        total++; if (snp_resp_valid !== 1'b1 || snp_resp_state !== S) begin
            bad++; $display("FAIL b2b_noop got rv=%b st=%b want 1/011", snp_resp_valid, snp_resp_state);
        end
        set_snp(1, RDINV, 7, 1, 1); clk_step();
        total++; if (snp_resp_valid !== 1'b1 || snp_resp_state !== M || snp_resp_supply !== 1'b1 || snp_resp_dirty !== 1'b1) begin
            bad++; $display("FAIL b2b_rdinv got rv=%b st=%b sup=%b dirty=%b want 1/000/1/1", snp_resp_valid, snp_resp_state, snp_resp_supply, snp_resp_dirty);
        end
        idle(); set_cpu(0, RDH, 7, 1, 0, 0); #1;
        total++; if (cpu_cur_state !== I) begin bad++; $display("FAIL b2b_inv_line got=%b want=%b", cpu_cur_state, I); end
        set_cpu(0, RDH, 7, 0, 0, 0); #1;
        total++; if (cpu_cur_state !== S) begin bad++; $display("FAIL b2b_noop_line got=%b want=%b", cpu_cur_state, S); end
    endtask

    task automatic test_random();
        logic [3:0] codes [4];
        logic [2:0] got;
        codes[0] = RD; codes[1] = RDINV; codes[2] = INV; codes[3] = 4'b0000;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            set_cpu($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                    $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            codes[3] = 4'($urandom_range(0, 15));
            set_snp($urandom_range(0, 1) != 0, codes[$urandom_range(0, 3)], $urandom_range(0, 3),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1));
            #1;
            exp_ready = !(snp_valid && snp_hit && snp_index == cpu_index && snp_way == cpu_way);
            total++; if (cpu_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", n, cpu_ready, exp_ready); end
            total++; if (cpu_cur_state !== mdl[cpu_index][cpu_way]) begin
                bad++; $display("FAIL rnd_cur[%0d] got=%b want=%b", n, cpu_cur_state, mdl[cpu_index][cpu_way]);
            end
            clk_step();
            total++; if (cpu_resp_valid !== exp_cpu_rv || cpu_need_inv !== exp_inv || cpu_wb !== exp_wb || cpu_err !== exp_err) begin
                bad++; $display("FAIL rnd_cpu_flags[%0d] got=%b%b%b%b want=%b%b%b%b", n, cpu_resp_valid, cpu_need_inv, cpu_wb, cpu_err, exp_cpu_rv, exp_inv, exp_wb, exp_err);
            end
            if (exp_cpu_rv) begin
                total++; if (cpu_prev_state !== exp_prev || cpu_next_state !== exp_next) begin
                    bad++; $display("FAIL rnd_cpu_states[%0d] got=%b/%b want=%b/%b", n, cpu_prev_state, cpu_next_state, exp_prev, exp_next);
                end
            end
            total++; if (snp_resp_valid !== exp_snp_rv || snp_resp_supply !== exp_supply || snp_resp_dirty !== exp_dirty) begin
                bad++; $display("FAIL rnd_snp_flags[%0d] got=%b%b%b want=%b%b%b", n, snp_resp_valid, snp_resp_supply, snp_resp_dirty, exp_snp_rv, exp_supply, exp_dirty);
            end
            if (snp_resp_valid === 1'b1 && exp_q.size() != 0) begin
                got = exp_q.pop_front();
                total++; if (snp_resp_state !== got) begin bad++; $display("FAIL rnd_snp_state[%0d] got=%b want=%b", n, snp_resp_state, got); end
            end
        end
        idle();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_snp_missing got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        set_cpu(1, WRH, 7, 0, 0, 0); ARESETn = 0; clk_step();
        total++; if (cpu_resp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_rv got=%b want=0", cpu_resp_valid); end
        idle(); ARESETn = 1; #1;
        total++; if (cpu_cur_state !== I) begin bad++; $display("FAIL rstmid_line got=%b want=%b", cpu_cur_state, I); end
        clk_step();
        total++; if (cpu_resp_valid !== 1'b0 || snp_resp_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_after got=%b%b want=00", cpu_resp_valid, snp_resp_valid);
        end
        set_cpu(0, RDH, 3, 1, 0, 0); #1;
        total++; if (cpu_cur_state !== I) begin bad++; $display("FAIL rstmid_other got=%b want=%b", cpu_cur_state, I); end
    endtask

    initial begin
        for (int s = 0; s < 16; s++) for (int w = 0; w < 2; w++) mdl[s][w] = I;
        #2;
        test_reset();
        test_fill();
        test_write_hit();
        test_snoop_evict();
        test_collision();
        test_diff_ways();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
